// File: rtl/xidx_pkg.sv
// xidx_pkg: shared state encoding and prefix/CB opcode constants for the index-prefix sequencer.
package xidx_pkg;
  typedef enum logic [2:0] {IDLE, PFX, OP, CB_DISP, CB_OP, CB_EXEC} xidx_state_e;
  // Entries 2-3 are team-assigned extension prefix codes.
  localparam logic [7:0] PFX_CODE [4] = '{8'hDD, 8'hFD, 8'hED, 8'hEE};
  localparam logic [7:0] CB_CODE = 8'hCB;
endpackage

// File: rtl/xidx_prefix_match.sv
// xidx_prefix_match: flags an opcode equal to one of the first N_IDX prefix codes and returns its index.
module xidx_prefix_match
  import xidx_pkg::*;
#(
  parameter int N_IDX = 2
) (
  input  logic [7:0] opcode_i,
  output logic       hit_o,
  output logic [1:0] idx_o
);
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = 0; k < N_IDX; k++) begin
      if (opcode_i == PFX_CODE[k]) begin
        hit_o = 1'b1;
        idx_o = 2'(k);
      end
    end
  end
endmodule

// File: rtl/xidx_prefix_seq.sv
// xidx_prefix_seq: index-prefix instruction sequencer with step counter and chained-prefix tracking.
// Define XIDX_PREFIX_SEQ_DDCB_EN to enable the indexed-CB (prefix, CB, disp, opcode) path.
module xidx_prefix_seq
  import xidx_pkg::*;
#(
  parameter int XPT_W   = 5,
  parameter int N_IDX   = 2,
  parameter int CHAIN_W = 3
) (
  input  logic               clock,
  input  logic               not_reset,
  input  logic               fetch_valid,
  input  logic [7:0]         opcode,
  input  logic               step_inc,
  input  logic               end_of_instr,
  output logic [XPT_W-1:0]   XPT,
  output logic [XPT_W-1:0]   notXPT,
  output logic [N_IDX-1:0]   idx_sel,
  output logic               is_Y,
  output logic [7:0]         op_q,
  output logic               op_valid,
  output logic [7:0]         disp,
  output logic               cb_mode,
  output logic               int_inhibit,
  output logic [CHAIN_W-1:0] chain_cnt
);
  xidx_state_e        state_q, state_d;
  logic [XPT_W-1:0]   xpt_q, xpt_d;
  logic [N_IDX-1:0]   idx_q, idx_d;
  logic [7:0]         opc_q, opc_d, disp_q, disp_d;
  logic               opv_q, opv_d;
  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic               hit, is_cb;
  logic [1:0]         hit_idx;

  xidx_prefix_match #(.N_IDX(N_IDX)) u_match (
    .opcode_i(opcode),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

`ifdef XIDX_PREFIX_SEQ_DDCB_EN
  assign is_cb   = opcode == CB_CODE;
  assign cb_mode = state_q inside {CB_DISP, CB_OP, CB_EXEC};
  assign disp    = disp_q;
`else
  assign is_cb   = 1'b0;
  assign cb_mode = 1'b0;
  assign disp    = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    xpt_d   = xpt_q;
    idx_d   = idx_q;
    opc_d   = opc_q;
    disp_d  = disp_q;
    opv_d   = 1'b0;
    chain_d = chain_q;
    unique case (state_q)
      IDLE, PFX: begin
        if (fetch_valid) begin
          if (hit) begin
            // Last prefix wins: idx_sel is replaced, not accumulated.
            state_d = PFX;
            idx_d   = N_IDX'(1) << hit_idx;
            xpt_d   = '0;
            chain_d = &chain_q ? chain_q : chain_q + CHAIN_W'(1);
          end else if (state_q == PFX && is_cb) begin
            state_d = CB_DISP;
          end else begin
            state_d = OP;
            opc_d   = opcode;
            xpt_d   = '0;
            opv_d   = 1'b1;
            idx_d   = state_q == IDLE ? '0 : idx_q;
          end
        end
      end
      CB_DISP: begin
        if (fetch_valid) begin
          disp_d  = opcode;
          state_d = CB_OP;
        end
      end
      CB_OP: begin
        if (fetch_valid) begin
          opc_d   = opcode;
          xpt_d   = '0;
          opv_d   = 1'b1;
          state_d = CB_EXEC;
        end
      end
      OP, CB_EXEC: begin
        if (end_of_instr) begin
          state_d = IDLE;
          xpt_d   = '0;
          idx_d   = '0;
          chain_d = '0;
        end else if (step_inc && !(&xpt_q)) begin
          xpt_d = xpt_q + XPT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q <= IDLE;
      xpt_q   <= '0;
      idx_q   <= '0;
      opc_q   <= '0;
      disp_q  <= '0;
      opv_q   <= 1'b0;
      chain_q <= '0;
    end else begin
      state_q <= state_d;
      xpt_q   <= xpt_d;
      idx_q   <= idx_d;
      opc_q   <= opc_d;
      disp_q  <= disp_d;
      opv_q   <= opv_d;
      chain_q <= chain_d;
    end
  end

  assign XPT         = xpt_q;
  assign notXPT      = ~xpt_q;
  assign idx_sel     = idx_q;
  assign op_q        = opc_q;
  assign op_valid    = opv_q;
  assign int_inhibit = state_q != IDLE;
  assign chain_cnt   = chain_q;

  if (N_IDX > 1) begin : g_y
    assign is_Y = idx_q[1];
  end else begin : g_no_y
    assign is_Y = 1'b0;
  end
endmodule
